// File: rtl/core_pkg.sv
// Shared RV32I core definitions: data widths, the canonical NOP and the fetch
// buffer entry layout.
package core_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; flush beats push, and a push
// into a full buffer is accepted when the head pops in the same cycle.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_flush,
  input  fetch_entry_t    i_wdata,
  output fetch_entry_t    o_head,
  output logic [CntW-1:0] o_count,
  output logic            o_full,
  output logic            o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [PtrW-1:0] r_rptr;
  logic [PtrW-1:0] r_wptr;
  logic [CntW-1:0] r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == CntW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch front-end: PC register, buffered {pc, instr} pairs toward decode
// and redirect handling with a sticky misalignment flag.
module instruction_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_err
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [31:0]     r_fetch_pc;
  logic            r_misalign;
  logic            w_pop;
  logic            w_push;
  logic            w_full;
  logic            w_empty;
  logic [CntW-1:0] w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_wdata;

  assign w_pop   = out_valid & out_ready;
  assign w_push  = fetch_en & ~redirect_valid & (~w_full | w_pop);
  assign w_wdata = '{pc: r_fetch_pc, instr: imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CntW  (CntW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) r_misalign <= 1'b1;
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + 32'(INSTR_BYTES);
    end
  end

  // Outputs depend only on registered FIFO state.
  assign imem_addr    = r_fetch_pc;
  assign misalign_err = r_misalign;
  assign out_valid    = (w_count != '0);
  assign out_instr    = w_empty ? NOP_INSTR : w_head.instr;
  assign out_pc       = w_empty ? 32'h0 : w_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, backpressure, redirect
// flush, misalignment, PC wrap and reset overriding redirect.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic [31:0] imem_addr, imem_rdata, out_instr, out_pc;
  logic        out_valid, misalign_err;
  logic [31:0] w_imem_addr, w_imem_rdata, w_out_instr, w_out_pc;
  logic        w_out_valid, w_misalign_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00E0_0093;
      32'h4:   return 32'h00B0_0113;
      32'h8:   return 32'h0020_81B3;
      default: return 32'h0;
    endcase
  endfunction

  always_comb imem_rdata   = mem_word(imem_addr);
  always_comb w_imem_rdata = mem_word(w_imem_addr);

  instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .misalign_err   (misalign_err)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_addr      (w_imem_addr),
    .imem_rdata     (w_imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (w_out_valid),
    .out_ready      (out_ready),
    .out_instr      (w_out_instr),
    .out_pc         (w_out_pc),
    .misalign_err   (w_misalign_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;

    // 1: reset state, then free streaming
    do_reset();
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_instr", out_instr, 32'h0000_0013);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_mis", {31'b0, misalign_err}, 32'h0);
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("s1_valid0", {31'b0, out_valid}, 32'h1);
    chk("s1_pc0", out_pc, 32'h0);
    chk("s1_in0", out_instr, 32'h00E0_0093);
    chk("s1_addr0", imem_addr, 32'h4);
    tick();
    chk("s1_pc1", out_pc, 32'h4);
    chk("s1_in1", out_instr, 32'h00B0_0113);
    tick();
    chk("s1_pc2", out_pc, 32'h8);
    chk("s1_in2", out_instr, 32'h0020_81B3);
    tick();
    chk("s1_valid3", {31'b0, out_valid}, 32'h1);
    chk("s1_pc3", out_pc, 32'hC);
    chk("s1_in3", out_instr, 32'h0);

    // 2: backpressure saturates the buffer and holds the PC
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    chk("s2_addr_hold", imem_addr, 32'h8);
    chk("s2_head_hold", out_pc, 32'h0);
    chk("s2_valid", {31'b0, out_valid}, 32'h1);
    out_ready = 1'b1;
    tick();
    chk("s2_pc4", out_pc, 32'h4);
    tick();
    chk("s2_pc8", out_pc, 32'h8);
    chk("s2_in8", out_instr, 32'h0020_81B3);
    tick();
    chk("s2_pcC", out_pc, 32'hC);

    // 3: redirect flushes a full buffer while the head pops
    out_ready = 1'b0;
    do_reset();
    tick();
    tick();
    chk("s3_full_head", out_pc, 32'h0);
    chk("s3_full_addr", imem_addr, 32'h8);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    tick();
    redirect_valid = 1'b0;
    chk("s3_flush_valid", {31'b0, out_valid}, 32'h0);
    chk("s3_flush_addr", imem_addr, 32'h8);
    tick();
    chk("s3_tgt_pc", out_pc, 32'h8);
    chk("s3_tgt_in", out_instr, 32'h0020_81B3);
    tick();
    chk("s3_next_pc", out_pc, 32'hC);

    // 4: misaligned redirect sets the sticky flag
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6;
    tick();
    redirect_valid = 1'b0;
    chk("s4_mis_set", {31'b0, misalign_err}, 32'h1);
    chk("s4_addr", imem_addr, 32'h4);
    chk("s4_valid", {31'b0, out_valid}, 32'h0);
    tick();
    chk("s4_pc", out_pc, 32'h4);
    chk("s4_in", out_instr, 32'h00B0_0113);
    tick();
    chk("s4_mis_sticky", {31'b0, misalign_err}, 32'h1);
    reset = 1'b1;
    tick();
    chk("s4_mis_clr", {31'b0, misalign_err}, 32'h0);

    // 5: PC wraps modulo 2^32
    chk("s5_rst_addr", w_imem_addr, 32'hFFFF_FFF8);
    reset = 1'b0;
    tick();
    chk("s5_pc0", w_out_pc, 32'hFFFF_FFF8);
    tick();
    chk("s5_pc1", w_out_pc, 32'hFFFF_FFFC);
    tick();
    chk("s5_pc2", w_out_pc, 32'h0);
    chk("s5_in2", w_out_instr, 32'h00E0_0093);

    // 6: reset wins over a simultaneous misaligned redirect
    out_ready = 1'b0;
    do_reset();
    tick();
    tick();
    chk("s6_full", {31'b0, out_valid}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    reset          = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("s6_valid", {31'b0, out_valid}, 32'h0);
    chk("s6_instr", out_instr, 32'h0000_0013);
    chk("s6_pc", out_pc, 32'h0);
    chk("s6_addr", imem_addr, 32'h0);
    chk("s6_mis", {31'b0, misalign_err}, 32'h0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch front-end of the RV32I core. Drives the word address into the combinational-read instruction memory and captures each returned instruction together with its PC. Buffers the pair in a small FIFO and presents it to decode over a valid/ready handshake. Execute can redirect the fetch stream at any time (branch/jump), which flushes every buffered entry.

## Interface

**Parameters**
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `DEPTH`, default `2`: fetch buffer entries. Must be a power of two and ≥ 2.

**Ports**
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `fetch_en` in 1: enables fetching. When 0, nothing is pushed and the PC holds.
- `imem_addr` out 32: byte address to instruction memory; always equals `fetch_pc`.
- `imem_rdata` in 32: instruction at `imem_addr`, valid in the same cycle (combinational read).
- `redirect_valid` in 1: single-cycle redirect request from execute.
- `redirect_pc` in 32: redirect target.
- `out_valid` out 1: buffer head is valid.
- `out_ready` in 1: decode accepts the head.
- `out_instr` out 32: head instruction; `32'h0000_0013` (NOP) when empty.
- `out_pc` out 32: head PC; `0` when empty.
- `misalign_err` out 1: sticky; set by a redirect with `redirect_pc[1:0] != 0`, cleared only by reset.

## Operation

- **State:**
  - `fetch_pc` (32 b).
  - FIFO of `{pc, instr}` entries, with read pointer, write pointer and `count` (0..DEPTH).
  - `misalign_err`.
- **Pop:** occurs when `out_valid & out_ready`.
- **Push condition:** `fetch_en & !redirect_valid & (count < DEPTH | pop)`.
  - A push writes `{fetch_pc, imem_rdata}` at the write pointer.
  - It then advances `fetch_pc <= fetch_pc + 4`, wrapping modulo 2^32 (`32'hFFFF_FFFC` → `0`).
- **Redirect (highest priority):**
  - `count <= 0` and both pointers reset to 0.
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - No push that cycle.
  - A pop in the same cycle still counts as consumed by decode; the remaining entries are discarded.
  - If `redirect_pc[1:0] != 0`, `misalign_err <= 1`.
- **Full buffer:** with `count == DEPTH` and no pop, there is no push and `fetch_pc` holds. `imem_addr` is stable, so the same word is re-read next cycle.
- **Empty buffer:** `out_valid = 0`; a pop is impossible.
- **Simultaneous push and pop at any count:** `count` is unchanged.
- **`fetch_en` low:** pops still drain the buffer. A redirect while `fetch_en` is low still flushes the buffer and loads the PC.
- **`imem_rdata` handling:** it is never interpreted. Illegal encodings pass through unchanged.
- **Reset (any cycle, including mid-stream or during a redirect):**
  - `fetch_pc = RESET_PC`, `count = 0`, pointers `= 0`, `misalign_err = 0`.
  - Outputs: `out_valid = 0`, `out_instr = 32'h0000_0013`, `out_pc = 0`, `imem_addr = RESET_PC`.
  - Reset overrides redirect.

## Timing

- `imem_addr` is a register output; `imem_rdata` is sampled at the same rising edge that advances the PC.
- **Latency:** an instruction fetched at edge N appears on `out_*` in the cycle after edge N (1 cycle from push to `out_valid`).
- **Throughput:** 1 instruction/cycle sustained with `out_ready` held high and `fetch_en` high. This holds at `DEPTH = 2` because push-while-full-with-pop is allowed.
- **First instruction:** reset deasserts at edge 0 with `fetch_en = 1`; `out_valid = 1` after edge 1, with `out_pc = RESET_PC`.
- **Redirect:** `redirect_valid` high before edge R gives `out_valid = 0` after R. The target instruction is visible after edge R+1.
- **Output derivation:** `out_valid`, `out_instr` and `out_pc` derive only from registered FIFO state; there is no combinational path from `out_ready` or `redirect_*`.

## Structure

- **Shared package `core_pkg`** holds:
  - `XLEN = 32`
  - `INSTR_BYTES = 4`
  - `NOP_INSTR = 32'h0000_0013`
  - `typedef struct packed { logic [31:0] pc; logic [31:0] instr; } fetch_entry_t;`
- **Sub-module `fetch_fifo`:** generic synchronous FIFO of `fetch_entry_t` with `push`, `pop`, `flush`, `count`, `full`, `empty` and a head output. Flush has priority over push.
- **Top level:** the PC register, push gating, redirect handling and the error flag live in `instruction_fetch`.

## Test plan

Memory image for all scenarios: word 0 = `32'h00E0_0093`, word 1 = `32'h00B0_0113`, word 2 = `32'h0020_81B3`; other words 0.

1. **Reset then stream:** reset, then `fetch_en = 1`, `out_ready = 1`.
   - Expect `{out_pc, out_instr}` = `{0, 00E00093}`, `{4, 00B00113}`, `{8, 002081B3}` on consecutive cycles, then `out_valid` stays high with instr `0`.
2. **Backpressure:** `out_ready = 0` for 5 cycles after the first push.
   - `count` saturates at 2 and `imem_addr` holds at `8`.
   - Release `out_ready`: pcs 0, 4, 8 are delivered in order with no loss or duplication.
3. **Redirect with flush:** buffer full (pcs 0, 4); pulse `redirect_valid` with `redirect_pc = 8` while `out_ready = 1`.
   - pc 0 is consumed; pc 4 is never output.
   - `out_valid = 0` for one cycle, then `{8, 002081B3}`.
4. **Misaligned redirect:** `redirect_pc = 32'h0000_0006`.
   - `misalign_err` rises and stays high; the next `out_pc` is `4`.
   - Reset clears `misalign_err`.
5. **Wrap-around:** `RESET_PC = 32'hFFFF_FFF8`; stream freely.
   - `out_pc` sequence is `FFFF_FFF8`, `FFFF_FFFC`, `0000_0000`.
6. **Reset mid-operation:** full buffer with `redirect_valid` and `reset` both high at one edge.
   - Next cycle: `out_valid = 0`, `out_instr = 0000_0013`, `imem_addr = RESET_PC`.
